// File: rtl/box_target_driver.sv
// box_target_driver: picks a pseudo-random target box and lights it on GPIO for a timed window, then a dark gap.
// Latency: target lit from the first DRIVE cycle; outputs registered, one cycle after the deciding edge.
// Backpressure: none; start is level-sampled only in IDLE, stop aborts from any state and wins over start.
//
// Ports:
//   clock, resetn        - system clock, asynchronous active-low reset
//   start, stop          - request one target cycle / abort
//   gpio_out[2:0]        - one-hot box drive (bit0 = box 1), 0 = dark
//   box_addr[2:0]        - one-hot of current/last target (sensor-side encoding)
//   target_idx[1:0]      - target index 1..3, 0 = none
//   busy, done           - high in PICK/DRIVE/GAP; one-cycle pulse on last GAP cycle
// Optional feature macro: BOX_NO_REPEAT_EN (never pick the same box twice in a row).

module box_target_driver #(
   parameter int unsigned TICK_DIV  = 50000,
   parameter int unsigned ON_TICKS  = 500,
   parameter int unsigned GAP_TICKS = 200,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       start,
   input  logic       stop,
   output logic [2:0] gpio_out,
   output logic [2:0] box_addr,
   output logic [1:0] target_idx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned MAX_TICKS = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
   localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV + 1)  : 1;
   localparam int TW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS + 1) : 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
   localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);

   generate
      if (ON_TICKS == 0 || GAP_TICKS == 0) begin : g_bad_ticks
         $error("box_target_driver: ON_TICKS and GAP_TICKS must be nonzero");
      end
      if (TICK_DIV == 0) begin : g_bad_div
         $error("box_target_driver: TICK_DIV must be nonzero");
      end
      if (LFSR_SEED == 8'h00) begin : g_bad_seed
         $error("box_target_driver: LFSR_SEED must be nonzero");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_PICK, S_DRIVE, S_GAP} state_t;

   state_t        r_state, w_nxt_state;
   logic [7:0]    r_lfsr;
   logic [PW-1:0] r_pre, w_nxt_pre;
   logic [TW-1:0] r_tick, w_nxt_tick;
   logic [2:0]    r_gpio, w_nxt_gpio;
   logic [2:0]    r_box, w_nxt_box;
   logic [1:0]    r_idx, w_nxt_idx;
   logic          r_busy, r_done;
   logic          w_nxt_done;
   logic [1:0]    w_cand;
   logic          w_cand_ok;
   logic          w_tick_end;
   logic          w_lfsr_fb;

   // x^8 + x^6 + x^5 + x^4 + 1, maximal length so the register never reaches 0
   assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_cand     = r_lfsr[1:0];
   assign w_tick_end = (r_pre == PRE_LAST);

`ifdef BOX_NO_REPEAT_EN
   // Last target that reached DRIVE, whether it later completed or was aborted
   logic [1:0] r_prev;
   assign w_cand_ok = (w_cand != 2'd3) && ((w_cand + 2'd1) != r_prev);
`else
   assign w_cand_ok = (w_cand != 2'd3);
`endif

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_pre   = r_pre;
      w_nxt_tick  = r_tick;
      w_nxt_gpio  = r_gpio;
      w_nxt_box   = r_box;
      w_nxt_idx   = r_idx;
      if (stop) begin
         w_nxt_state = S_IDLE;
         w_nxt_pre   = '0;
         w_nxt_tick  = '0;
         w_nxt_gpio  = '0;
         w_nxt_box   = '0;
         w_nxt_idx   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) w_nxt_state = S_PICK;
            end
            S_PICK: begin
               // A rejected candidate simply waits for the next LFSR value
               if (w_cand_ok) begin
                  w_nxt_state = S_DRIVE;
                  w_nxt_pre   = '0;
                  w_nxt_tick  = '0;
                  w_nxt_gpio  = 3'b001 << w_cand;
                  w_nxt_box   = 3'b001 << w_cand;
                  w_nxt_idx   = w_cand + 2'd1;
               end
            end
            S_DRIVE: begin
               if (w_tick_end) begin
                  w_nxt_pre = '0;
                  if (r_tick == ON_LAST) begin
                     w_nxt_state = S_GAP;
                     w_nxt_tick  = '0;
                     w_nxt_gpio  = '0;
                  end else begin
                     w_nxt_tick = r_tick + TW'(1);
                  end
               end else begin
                  w_nxt_pre = r_pre + PW'(1);
               end
            end
            S_GAP: begin
               if (w_tick_end) begin
                  w_nxt_pre = '0;
                  if (r_tick == GAP_LAST) begin
                     w_nxt_state = S_IDLE;
                     w_nxt_tick  = '0;
                  end else begin
                     w_nxt_tick = r_tick + TW'(1);
                  end
               end else begin
                  w_nxt_pre = r_pre + PW'(1);
               end
            end
            default: w_nxt_state = S_IDLE;
         endcase
      end
      // done is registered, so it is raised when the upcoming cycle is the last GAP cycle
      w_nxt_done = (w_nxt_state == S_GAP) && (w_nxt_pre == PRE_LAST) && (w_nxt_tick == GAP_LAST);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_lfsr  <= LFSR_SEED;
         r_pre   <= '0;
         r_tick  <= '0;
         r_gpio  <= '0;
         r_box   <= '0;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_lfsr  <= {r_lfsr[6:0], w_lfsr_fb};
         r_pre   <= w_nxt_pre;
         r_tick  <= w_nxt_tick;
         r_gpio  <= w_nxt_gpio;
         r_box   <= w_nxt_box;
         r_idx   <= w_nxt_idx;
         r_busy  <= (w_nxt_state != S_IDLE);
         r_done  <= w_nxt_done;
      end
   end

`ifdef BOX_NO_REPEAT_EN
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_prev <= '0;
      end else if (r_state == S_PICK && w_nxt_state == S_DRIVE) begin
         r_prev <= w_nxt_idx;
      end
   end
`endif

   assign gpio_out   = r_gpio;
   assign box_addr   = r_box;
   assign target_idx = r_idx;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_box_target_driver.sv
// tb_box_target_driver: randomized transaction-level check of box_target_driver against a
// cycle-count reference (LFSR sequence, pick dwell, 12-cycle window, 8-cycle gap).
// TICK_DIV=4, ON_TICKS=3, GAP_TICKS=2.

module tb_box_target_driver;

   localparam int ON_CYC  = 12;
   localparam int GAP_CYC = 8;

   logic       clock  = 1'b0;
   logic       resetn = 1'b0;
   logic       start  = 1'b0;
   logic       stop   = 1'b0;
   logic [2:0] gpio_out;
   logic [2:0] box_addr;
   logic [1:0] target_idx;
   logic       busy;
   logic       done;

   box_target_driver #(
      .TICK_DIV (4),
      .ON_TICKS (3),
      .GAP_TICKS(2),
      .LFSR_SEED(8'hA5)
   ) dut (
      .clock     (clock),
      .resetn    (resetn),
      .start     (start),
      .stop      (stop),
      .gpio_out  (gpio_out),
      .box_addr  (box_addr),
      .target_idx(target_idx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference LFSR value as seen by the design during the current cycle
   logic [7:0] m_lfsr;
   int  hist = 0;       // last target that was lit (completed or aborted)
   int  last_tgt = 0;
   bit  seen [1:3];
   int  rep_cnt = 0;

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic bit cand_bad(input logic [7:0] l, input int h);
      bit b;
      b = (l[1:0] == 2'd3);
`ifdef BOX_NO_REPEAT_EN
      if (int'(l[1:0]) + 1 == h) b = 1'b1;
`endif
      return b;
   endfunction

   always @(posedge clock or negedge resetn) begin
      if (!resetn) m_lfsr = 8'hA5;
      else         m_lfsr = lfsr_step(m_lfsr);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_gpio"}, gpio_out, 3'b000);
   endtask

   // Called at a negedge with the design in IDLE; returns at a negedge with the design in IDLE.
   task automatic run_txn(input bit hold, input int abort_at);
      logic [7:0] l;
      int         picks;
      int         tgt;
      logic [2:0] oh;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      if (!hold) start = 1'b0;
      l = m_lfsr;
      picks = 1;
      while (cand_bad(l, hist) && picks < 600) begin
         l = lfsr_step(l);
         picks++;
      end
      tgt  = int'(l[1:0]) + 1;
      oh   = 3'b001 << l[1:0];
      hist = tgt;
      seen[tgt] = 1'b1;
      if (tgt == last_tgt) rep_cnt++;
      last_tgt = tgt;
      for (int i = 0; i < picks; i++) begin
         chk("pick_busy", busy, 1'b1);
         chk("pick_gpio", gpio_out, 3'b000);
         @(negedge clock);
      end
      for (int i = 1; i <= ON_CYC; i++) begin
         chk("drv_gpio", gpio_out, oh);
         chk("drv_box", box_addr, oh);
         chk("drv_idx", target_idx, tgt);
         chk("drv_onehot", $onehot(gpio_out), 1'b1);
         chk("drv_busy", busy, 1'b1);
         chk("drv_done", done, 1'b0);
         if (i == abort_at) begin
            stop  = 1'b1;
            start = 1'b1;
            @(posedge clock);
            @(negedge clock);
            stop  = 1'b0;
            start = 1'b0;
            chk_idle("abort");
            chk("abort_box", box_addr, 3'b000);
            chk("abort_idx", target_idx, 2'd0);
            @(negedge clock);
            chk_idle("abort_start_ignored");
            return;
         end
         if (!hold) start = ($urandom_range(0, 3) == 0);
         @(negedge clock);
      end
      for (int i = 1; i <= GAP_CYC; i++) begin
         chk("gap_gpio", gpio_out, 3'b000);
         chk("gap_box", box_addr, oh);
         chk("gap_idx", target_idx, tgt);
         chk("gap_busy", busy, 1'b1);
         chk("gap_done", done, (i == GAP_CYC));
         if (!hold) start = (i < GAP_CYC) && ($urandom_range(0, 3) == 0);
         @(negedge clock);
      end
      chk_idle("post");
      chk("post_box", box_addr, oh);
      chk("post_idx", target_idx, tgt);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_txn;
      int k;
      // Reset state
      repeat (3) @(negedge clock);
      chk_idle("reset");
      chk("reset_box", box_addr, 3'b000);
      chk("reset_idx", target_idx, 2'd0);
      resetn = 1'b1;
      @(negedge clock);
      chk_idle("reset_rel");

      // Basic timing, then start held high for back-to-back cycles
      run_txn(1'b0, 0);
      run_txn(1'b1, 0);
      run_txn(1'b1, 0);
      run_txn(1'b0, 0);

      // Abort on DRIVE cycle 5 with a simultaneous start
      run_txn(1'b0, 5);

`ifdef BOX_NO_REPEAT_EN
      n_txn = 500;
`else
      n_txn = 200;
`endif
      for (int t = 0; t < n_txn; t++) begin
         run_txn(1'b0, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, ON_CYC)) : 0);
         k = int'($urandom_range(0, 3));
         for (int g = 0; g < k; g++) begin
            @(negedge clock);
            chk_idle("gap_idle");
         end
      end
      chk("seen_box1", seen[1], 1'b1);
      chk("seen_box2", seen[2], 1'b1);
      chk("seen_box3", seen[3], 1'b1);
`ifdef BOX_NO_REPEAT_EN
      chk("no_repeat", rep_cnt, 0);
`else
      chk("repeat_seen", (rep_cnt > 0), 1'b1);
`endif

      // Asynchronous reset in the middle of DRIVE
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      k = 0;
      while (gpio_out == 3'b000 && k < 600) begin
         @(negedge clock);
         k++;
      end
      chk("rst_reached_drive", (gpio_out != 3'b000), 1'b1);
      @(negedge clock);
      @(negedge clock);
      #1 resetn = 1'b0;
      #1;
      chk("rst_async_gpio", gpio_out, 3'b000);
      chk("rst_async_busy", busy, 1'b0);
      @(negedge clock);
      @(negedge clock);
      resetn   = 1'b1;
      hist     = 0;
      last_tgt = 0;
      chk_idle("rst_release");
      chk("rst_release_box", box_addr, 3'b000);
      chk("rst_release_idx", target_idx, 2'd0);
      @(negedge clock);
      chk_idle("rst_idle");
      run_txn(1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
